// File: rtl/fpu_pkg.sv
// Shared encodings and the flag helper for the FP request sequencer.
package fpu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;

  localparam int FLG_INE       = 0;
  localparam int FLG_OVERFLOW  = 1;
  localparam int FLG_UNDERFLOW = 2;
  localparam int FLG_DIV_ZERO  = 3;
  localparam int FLG_INF       = 4;
  localparam int FLG_ZERO      = 5;
  localparam int FLG_QNAN      = 6;
  localparam int FLG_SNAN      = 7;
  localparam int FLG_ILLEGAL   = 8;

  localparam logic [31:0] QNAN_CANON = 32'h7FC00000;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  // Signalling NaN: all-ones exponent, quiet bit clear, payload non-zero.
  function automatic logic is_snan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && !x[22] && (x[21:0] != 22'd0);
  endfunction

  function automatic logic [8:0] calc_flags(input logic [31:0] r,
                                            input logic [31:0] opa,
                                            input logic [31:0] opb,
                                            input logic [2:0]  op,
                                            input logic        ine_in);
    logic [8:0] f;
    logic       ine;
    ine                = (op == OP_MUL) ? 1'b0 : ine_in;
    f                  = '0;
    f[FLG_SNAN]        = is_snan(opa) || is_snan(opb);
    f[FLG_QNAN]        = (r[30:23] == 8'hFF) && r[22];
    f[FLG_ZERO]        = (r[30:0] == 31'd0);
    f[FLG_INF]         = (r[30:23] == 8'hFF) && (r[22:0] == 23'd0);
    f[FLG_DIV_ZERO]    = (op == OP_DIV) && (opb[30:0] == 31'd0);
    f[FLG_UNDERFLOW]   = (r[30:23] == 8'h00) && ine;
    f[FLG_OVERFLOW]    = (r[30:23] == 8'hFF) && ine;
    f[FLG_INE]         = ine;
    return f;
  endfunction

endpackage

// File: rtl/fpu_req_fifo.sv
// Synchronous request FIFO; extra pointer bit distinguishes full from empty.
module fpu_req_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic         do_push;
  logic         do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rptr[AW-1:0]];
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/fpu_seq.sv
// Queues FP requests, issues them one at a time to an external core and
// returns result, tag and IEEE flags over a valid/ready response port.
module fpu_seq
  import fpu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int ADD_LAT = 4,
  parameter int MUL_LAT = 2,
  parameter int DIV_EN  = 0,
  parameter int DIV_LAT = 27
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [31:0]      req_opa_i,
  input  logic [31:0]      req_opb_i,
  input  logic [2:0]       req_op_i,
  input  logic [1:0]       req_rmode_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic             core_start_o,
  output logic [31:0]      core_opa_o,
  output logic [31:0]      core_opb_o,
  output logic [2:0]       core_op_o,
  output logic [1:0]       core_rmode_o,
  input  logic [31:0]      core_result_i,
  input  logic             core_ine_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [31:0]      rsp_result_o,
  output logic [TAG_W-1:0] rsp_tag_o,
  output logic [8:0]       rsp_flags_o,
  output logic             busy_o
);

  // Both sides use valid/ready: a transfer happens on a rising edge where
  // valid and ready are both high; valid holds its payload stable until then.

  localparam int LAT_AM  = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT;
  localparam int MAX_LAT = ((DIV_EN != 0) && (DIV_LAT > LAT_AM)) ? DIV_LAT : LAT_AM;
  localparam int CW      = $clog2(MAX_LAT) + 1;
  localparam int FW      = TAG_W + 69;

  state_t           state, state_nx;
  logic [FW-1:0]    wdata, rdata;
  logic             full, empty, push, pop;
  logic [31:0]      h_opa, h_opb;
  logic [2:0]       h_op;
  logic [1:0]       h_rmode;
  logic [TAG_W-1:0] h_tag;
  logic             h_legal;
  logic [CW-1:0]    cnt, lat_sel;
  logic             capture;

  assign wdata   = {req_opa_i, req_opb_i, req_op_i, req_rmode_i, req_tag_i};
  assign h_opa   = rdata[FW-1 -: 32];
  assign h_opb   = rdata[FW-33 -: 32];
  assign h_op    = rdata[TAG_W+4 -: 3];
  assign h_rmode = rdata[TAG_W+1 -: 2];
  assign h_tag   = rdata[TAG_W-1:0];
  assign h_legal = (h_op == OP_ADD) || (h_op == OP_SUB) || (h_op == OP_MUL) ||
                   ((h_op == OP_DIV) && (DIV_EN != 0));

  assign req_ready_o = !full;
  assign push        = req_valid_i && req_ready_o;

  fpu_req_fifo #(.DEPTH(DEPTH), .W(FW)) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    lat_sel = CW'(DIV_LAT);
    case (core_op_o)
      OP_ADD, OP_SUB: lat_sel = CW'(ADD_LAT);
      OP_MUL:         lat_sel = CW'(MUL_LAT);
      default:        lat_sel = CW'(DIV_LAT);
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    capture  = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          state_nx = h_legal ? S_ISSUE : S_RESP;
        end
      end
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT: begin
        if (cnt == lat_sel) begin
          capture  = 1'b1;
          state_nx = S_RESP;
        end
      end
      S_RESP: if (rsp_ready_i) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign core_start_o = (state == S_ISSUE);
  assign rsp_valid_o  = (state == S_RESP);
  assign busy_o       = (state != S_IDLE) || !empty;

  // core_* registers change only on pop, so they stay stable through capture.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      core_opa_o   <= '0;
      core_opb_o   <= '0;
      core_op_o    <= '0;
      core_rmode_o <= '0;
      rsp_tag_o    <= '0;
      rsp_result_o <= '0;
      rsp_flags_o  <= '0;
      cnt          <= '0;
    end else begin
      if (pop) begin
        core_opa_o   <= h_opa;
        core_opb_o   <= h_opb;
        core_op_o    <= h_op;
        core_rmode_o <= h_rmode;
        rsp_tag_o    <= h_tag;
        if (!h_legal) begin
          rsp_result_o              <= QNAN_CANON;
          rsp_flags_o               <= '0;
          rsp_flags_o[FLG_ILLEGAL]  <= 1'b1;
        end
      end
      if (state == S_ISSUE) cnt <= CW'(1);
      else if ((state == S_WAIT) && !capture) cnt <= cnt + 1'b1;
      if (capture) begin
        rsp_result_o <= core_result_i;
        rsp_flags_o  <= calc_flags(core_result_i, core_opa_o, core_opb_o,
                                   core_op_o, core_ine_i);
      end
    end
  end

endmodule

// File: tb/tb_fpu_seq.sv
// Directed bench for fpu_seq: latency, backpressure, queue fill, illegal ops,
// flag generation and reset abort, against hand-computed expectations.
module tb_fpu_seq;

  logic        clk, rst;
  logic        req_valid, req_valid_d, rsp_ready;
  logic [31:0] req_opa, req_opb, core_result;
  logic [2:0]  req_op;
  logic [1:0]  req_rmode;
  logic [3:0]  req_tag;
  logic        core_ine;

  logic        req_ready, core_start, rsp_valid, busy;
  logic [31:0] core_opa, core_opb, rsp_result;
  logic [2:0]  core_op;
  logic [1:0]  core_rmode;
  logic [3:0]  rsp_tag;
  logic [8:0]  rsp_flags;

  logic        req_ready_d, core_start_d, rsp_valid_d, busy_d;
  logic [31:0] core_opa_d, core_opb_d, rsp_result_d;
  logic [2:0]  core_op_d;
  logic [1:0]  core_rmode_d;
  logic [3:0]  rsp_tag_d;
  logic [8:0]  rsp_flags_d;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int starts = 0;
  int start_cyc = 0;
  logic [31:0] exp_q[$];

  fpu_seq dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_opa_i(req_opa), .req_opb_i(req_opb), .req_op_i(req_op),
    .req_rmode_i(req_rmode), .req_tag_i(req_tag), .core_start_o(core_start),
    .core_opa_o(core_opa), .core_opb_o(core_opb), .core_op_o(core_op),
    .core_rmode_o(core_rmode), .core_result_i(core_result), .core_ine_i(core_ine),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_result_o(rsp_result),
    .rsp_tag_o(rsp_tag), .rsp_flags_o(rsp_flags), .busy_o(busy)
  );

  fpu_seq #(.DIV_EN(1), .DIV_LAT(3)) dut_div (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid_d), .req_ready_o(req_ready_d),
    .req_opa_i(req_opa), .req_opb_i(req_opb), .req_op_i(req_op),
    .req_rmode_i(req_rmode), .req_tag_i(req_tag), .core_start_o(core_start_d),
    .core_opa_o(core_opa_d), .core_opb_o(core_opb_d), .core_op_o(core_op_d),
    .core_rmode_o(core_rmode_d), .core_result_i(core_result), .core_ine_i(core_ine),
    .rsp_valid_o(rsp_valid_d), .rsp_ready_i(rsp_ready), .rsp_result_o(rsp_result_d),
    .rsp_tag_o(rsp_tag_d), .rsp_flags_o(rsp_flags_d), .busy_o(busy_d)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (core_start) begin
      starts    <= starts + 1;
      start_cyc <= cyc;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit d, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] op, input logic [3:0] tag, output int t0);
    req_opa = a; req_opb = b; req_op = op; req_tag = tag; req_rmode = 2'd1;
    if (d) req_valid_d = 1'b1;
    else   req_valid   = 1'b1;
    t0 = cyc;
    step();
    req_valid   = 1'b0;
    req_valid_d = 1'b0;
  endtask

  task automatic wait_rsp(input bit d, input int t0, output int lat);
    lat = -1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (d ? rsp_valid_d : rsp_valid) begin
        lat = cyc - t0;
        break;
      end
    end
    if (lat < 0) check("rsp_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int t0, t1, lat, s0, hs, extra, i, guard;
    logic rdy;
    logic [31:0] v_opa [4] = '{32'h7F800001, 32'h7F000000, 32'h3F800000, 32'h00800000};
    logic [31:0] v_opb [4] = '{32'h3F800000, 32'h7F000000, 32'h3F800000, 32'h80800001};
    logic [2:0]  v_op  [4] = '{3'd0, 3'd0, 3'd1, 3'd0};
    logic [31:0] v_res [4] = '{32'h7FC00000, 32'h7F800000, 32'h80000000, 32'h00000001};
    logic        v_ine [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [8:0]  v_flg [4] = '{9'h0C0, 9'h013, 9'h020, 9'h005};

    rst = 1'b1; req_valid = 1'b0; req_valid_d = 1'b0; rsp_ready = 1'b1;
    req_opa = '0; req_opb = '0; req_op = '0; req_rmode = '0; req_tag = '0;
    core_result = '0; core_ine = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_core_start", {31'd0, core_start}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rsp_result", rsp_result, 32'd0);
    check("rst_flags", {23'd0, rsp_flags}, 32'd0);
    check("rst_core_opa", core_opa, 32'd0);
    rst = 1'b0;
    step();

    // add at default latency
    core_result = 32'h40400000; core_ine = 1'b0;
    send(0, 32'h3F800000, 32'h40000000, 3'd0, 4'd5, t0);
    wait_rsp(0, t0, lat);
    check("add_latency", lat, 32'd7);
    check("add_start_cycle", start_cyc - t0, 32'd2);
    check("add_result", rsp_result, 32'h40400000);
    check("add_tag", {28'd0, rsp_tag}, 32'd5);
    check("add_flags", {23'd0, rsp_flags}, 32'd0);
    check("add_core_opb", core_opb, 32'h40000000);
    check("add_core_rmode", {30'd0, core_rmode}, 32'd1);
    step();
    @(negedge clk);
    check("add_valid_drop", {31'd0, rsp_valid}, 32'd0);
    check("add_busy_drop", {31'd0, busy}, 32'd0);
    step();

    // mul with backpressure, second request queued behind it
    rsp_ready = 1'b0;
    core_result = 32'h40C00000; core_ine = 1'b1;
    send(0, 32'h40000000, 32'h40400000, 3'd2, 4'd1, t0);
    send(0, 32'h3F800000, 32'h00000000, 3'd0, 4'd2, t1);
    wait_rsp(0, t0, lat);
    check("mul_latency", lat, 32'd5);
    check("mul_result", rsp_result, 32'h40C00000);
    check("mul_flags_ine_forced", {23'd0, rsp_flags}, 32'd0);
    check("mul_tag", {28'd0, rsp_tag}, 32'd1);
    s0 = starts;
    repeat (3) begin
      @(negedge clk);
      check("bp_valid_held", {31'd0, rsp_valid}, 32'd1);
      check("bp_result_held", rsp_result, 32'h40C00000);
      check("bp_no_start", starts, s0);
    end
    hs = cyc;
    rsp_ready = 1'b1;
    core_result = 32'h3F800000; core_ine = 1'b1;
    step();
    wait_rsp(0, t1, lat);
    check("next_start_after_hs", start_cyc - hs, 32'd2);
    check("next_tag", {28'd0, rsp_tag}, 32'd2);
    check("next_result", rsp_result, 32'h3F800000);
    check("next_flags", {23'd0, rsp_flags}, 32'h001);
    step();

    // illegal ops: div with DIV_EN=0, and reserved op 6
    s0 = starts;
    send(0, 32'h3F800000, 32'h3F800000, 3'd3, 4'd3, t0);
    wait_rsp(0, t0, lat);
    check("ill_div_latency", lat, 32'd2);
    check("ill_div_result", rsp_result, 32'h7FC00000);
    check("ill_div_flags", {23'd0, rsp_flags}, 32'h100);
    check("ill_div_tag", {28'd0, rsp_tag}, 32'd3);
    step();
    send(0, 32'h3F800000, 32'h3F800000, 3'd6, 4'd4, t0);
    wait_rsp(0, t0, lat);
    check("ill_op6_latency", lat, 32'd2);
    check("ill_op6_result", rsp_result, 32'h7FC00000);
    check("ill_op6_flags", {23'd0, rsp_flags}, 32'h100);
    step();
    check("ill_no_start", starts, s0);

    // flag table: snan/qnan, overflow, zero, underflow
    for (int k = 0; k < 4; k++) begin
      core_result = v_res[k]; core_ine = v_ine[k];
      send(0, v_opa[k], v_opb[k], v_op[k], 4'(k + 8), t0);
      wait_rsp(0, t0, lat);
      check($sformatf("flags_vec%0d", k), {23'd0, rsp_flags}, {23'd0, v_flg[k]});
      check($sformatf("result_vec%0d", k), rsp_result, v_res[k]);
      step();
    end

    // divide by zero on the divide-enabled instance
    core_result = 32'h7F800000; core_ine = 1'b0;
    send(1, 32'h3F800000, 32'h00000000, 3'd3, 4'd7, t0);
    wait_rsp(1, t0, lat);
    check("div_latency", lat, 32'd6);
    check("div_flags", {23'd0, rsp_flags_d}, 32'h018);
    check("div_tag", {28'd0, rsp_tag_d}, 32'd7);
    step();

    // fill the queue with responses held off
    rsp_ready = 1'b0;
    core_result = 32'h40800000; core_ine = 1'b0;
    i = 0; guard = 0;
    while (i < 5 && guard < 50) begin
      req_opa = 32'h40000000; req_opb = 32'h40000000; req_op = 3'd2;
      req_tag = 4'(i); req_valid = 1'b1;
      @(negedge clk);
      rdy = req_ready;
      step();
      if (rdy) begin
        exp_q.push_back(32'(i));
        i++;
      end
      guard++;
    end
    req_valid = 1'b0;
    check("fill_accepted", i, 32'd5);
    @(negedge clk);
    check("fill_ready_low", {31'd0, req_ready}, 32'd0);
    req_tag = 4'd9; req_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      wait_rsp(0, cyc, lat);
      if (exp_q.size() > 0) check("fill_tag_order", {28'd0, rsp_tag}, exp_q.pop_front());
      check("fill_result", rsp_result, 32'h40800000);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
    end
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid) extra++;
    end
    check("fill_no_extra_rsp", extra, 32'd0);
    check("fill_idle", {31'd0, busy}, 32'd0);
    rsp_ready = 1'b1;
    step();

    // reset in the middle of WAIT
    core_result = 32'h12345678; core_ine = 1'b0;
    send(0, 32'h3F800000, 32'h3F800000, 3'd0, 4'd6, t0);
    repeat (3) step();
    rst = 1'b1;
    #1;
    check("rstw_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rstw_req_ready", {31'd0, req_ready}, 32'd1);
    check("rstw_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (rsp_valid) extra++;
    end
    check("rstw_no_late_rsp", extra, 32'd0);
    step();
    core_result = 32'h40000000;
    send(0, 32'h3F800000, 32'h3F800000, 3'd0, 4'd11, t0);
    wait_rsp(0, t0, lat);
    check("rstw_recover_latency", lat, 32'd7);
    check("rstw_recover_result", rsp_result, 32'h40000000);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fpu_seq.md
Name: fpu_seq

Overview:
- Parametrised request sequencer for the single-precision FP datapath.
- Buffers operation requests in a DEPTH-entry FIFO and issues them one at a time to an external arithmetic core.
- Uses a per-op latency counter to know when the core result is valid, then returns result, tag and IEEE status flags over a valid/ready response port with backpressure.
- Supersedes the fixed-latency start/ready controller: adds queuing, tags, configurable latencies, optional divide and illegal-op handling.

Parameters:
- DEPTH, 4: request FIFO entries; power of 2, >=2.
- TAG_W, 4: width of the request tag, returned unchanged with the response.
- ADD_LAT, 4: core cycles for add/sub; >=1.
- MUL_LAT, 2: core cycles for mul; >=1.
- DIV_EN, 0: 1 = op 3 (div) is legal; 0 = op 3 is illegal.
- DIV_LAT, 27: core cycles for div; >=1. Used only when DIV_EN=1.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  FIFO not full
- req_opa_i  in  32  operand A
- req_opb_i  in  32  operand B
- req_op_i  in  3  0 add, 1 sub, 2 mul, 3 div, 4-7 reserved
- req_rmode_i  in  2  rounding mode
- req_tag_i  in  TAG_W  request tag
- core_start_o  out  1  one-cycle issue pulse
- core_opa_o  out  32  registered operand A to core
- core_opb_o  out  32  registered operand B to core
- core_op_o  out  3  registered op to core
- core_rmode_o  out  2  registered rounding mode to core
- core_result_i  in  32  core result
- core_ine_i  in  1  core inexact flag
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response accepted
- rsp_result_o  out  32  result
- rsp_tag_o  out  TAG_W  tag of the request being answered
- rsp_flags_o  out  9  {illegal, snan, qnan, zero, inf, div_zero, underflow, overflow, ine}; bit 8 to bit 0
- busy_o  out  1  state != IDLE or FIFO non-empty

Behaviour:
- Reset:
  - Clock is clk_i. Reset rst_i is asynchronous and active-high.
  - On reset: FIFO empty, state IDLE; req_ready_o=1; rsp_valid_o=0; core_start_o=0; busy_o=0.
  - rsp_result_o, rsp_flags_o, rsp_tag_o, core_* data outputs all reset to 0.
  - Reset mid-operation aborts the operation. A core result arriving after reset is ignored.
- FIFO:
  - Push when req_valid_i & req_ready_o.
  - req_ready_o = !full, registered; it never depends on pop in the same cycle.
  - Push and pop in the same cycle are allowed while non-empty.
  - Pointers are $clog2(DEPTH)+1 bits, wrap-around compare for full/empty.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: if FIFO non-empty, pop head into the core_* registers and tag register.
    - Legal op -> ISSUE.
    - Illegal op (4-7, or 3 with DIV_EN=0) -> RESP with result 32'h7FC00000, illegal=1, all other flags 0.
  - ISSUE: core_start_o=1 for exactly this cycle; load cnt=1; -> WAIT.
  - WAIT: when cnt==LAT(op), capture core_result_i and core_ine_i and compute flags -> RESP. Otherwise cnt++.
    - cnt width is $clog2(max LAT)+1.
    - LAT=1 captures on the first WAIT edge.
  - RESP: rsp_valid_o=1, outputs held stable until rsp_ready_i; then -> IDLE.
- Latency, request accepted in cycle T with the FIFO empty and the FSM in IDLE:
  - Pop at the end of T+1; core_start_o high in T+2.
  - rsp_valid_o first high in T+3+LAT. Add = T+7, mul = T+5 at defaults.
  - Illegal op: rsp_valid_o first high in T+2.
- Throughput: one op in flight. The next pop is no earlier than the cycle after the response handshake.
- Flags, computed at capture from the result R and the latched operands:
  - zero: R[30:0]==0.
  - inf: R[30:23]==FF and R[22:0]==0.
  - qnan: R[30:23]==FF and R[22]==1.
  - snan: either operand has exp FF, frac[22]==0 and frac!=0.
  - overflow: R[30:23]==FF and ine.
  - underflow: R[30:23]==0 and ine.
  - div_zero: op==3 and opb[30:0]==0.
  - ine: core_ine_i for add/sub/div; forced 0 for mul.
- core_op_o, core_rmode_o and the operand outputs stay stable from ISSUE until capture.

Decomposition:
- fpu_pkg holds:
  - op encodings: OP_ADD, OP_SUB, OP_MUL, OP_DIV;
  - flag bit indices FLG_*;
  - QNAN_CANON = 32'h7FC00000;
  - FSM state encoding.
- Sub-module fpu_req_fifo: parametrised DEPTH x (32+32+3+2+TAG_W) synchronous FIFO with full/empty.

Test Plan:
- Add, defaults: req opa=3F800000, opb=40000000, op=0, tag=5 at T; core returns 40400000, ine=0 -> rsp_valid at T+7, result 40400000, tag 5, flags 0.
- Mul backpressure: opa=40000000, opb=40400000, op=2; core returns 40C00000; rsp_ready_i low 3 cycles -> result 40C00000 held stable, no new core_start_o until the handshake.
- Fill: 5 back-to-back requests, DEPTH=4, rsp_ready_i=1 -> req_ready_o low once 4 entries are queued; all 5 responses arrive in order with tags 0..4.
- Illegal and div:
  - op=3 with DIV_EN=0 -> core_start_o never pulses; rsp at T+2, result 7FC00000, flags=9'h100.
  - op=6 -> same response.
- Special operands: opa=7F800001 (sNaN), core returns 7FC00000 -> snan=1, qnan=1, inf=0. With DIV_EN=1, opb=0 div -> div_zero=1.
- Reset during WAIT: assert rst_i mid-count -> rsp_valid_o=0, req_ready_o=1, FIFO empty immediately; a late core result produces no response.
